// File: rtl/bcd_updown_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter_if : control and status bundle of the BCD up/down counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  d;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  carry;
  logic                  sat;
  logic                  tc;

  modport master (
    output en, d, load, load_val,
    input  count, carry, sat, tc
  );

  modport slave (
    input  en, d, load, load_val,
    output count, carry, sat, tc
  );
endinterface

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter : DIGITS-wide BCD up/down counter, wrap or saturate mode
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_updown_counter #(
  parameter int DIGITS  = 4,
  parameter int WRAP_EN = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,
  bcd_updown_counter_if.slave  bus
);

  localparam int          c_W    = 4 * DIGITS;
  localparam logic [3:0]  c_NINE = 4'd9;

  logic [c_W-1:0] r_count;
  logic           r_carry;
  logic           r_sat;

  logic [c_W-1:0] w_next;
  logic [c_W-1:0] w_sane;
  logic [3:0]     w_dig;
  logic [3:0]     w_ld;
  logic           w_lo9;
  logic           w_lo0;
  logic           w_tc;

  // w_lo9/w_lo0 accumulate "all lower digits are 9/0"; after the loop they
  // cover every digit and give the terminal count directly.
  always_comb begin
    w_next = r_count;
    w_sane = '0;
    w_dig  = '0;
    w_ld   = '0;
    w_lo9  = 1'b1;
    w_lo0  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig = r_count[4*i +: 4];
      if (bus.d) begin
        if (w_lo0)
          w_next[4*i +: 4] = (w_dig == 4'd0) ? c_NINE : w_dig - 4'd1;
      end else begin
        if (w_lo9)
          w_next[4*i +: 4] = (w_dig == c_NINE) ? 4'd0 : w_dig + 4'd1;
      end
      w_lo9 = w_lo9 & (w_dig == c_NINE);
      w_lo0 = w_lo0 & (w_dig == 4'd0);
      w_ld  = bus.load_val[4*i +: 4];
      w_sane[4*i +: 4] = (w_ld > c_NINE) ? c_NINE : w_ld;
    end
    w_tc = bus.d ? w_lo0 : w_lo9;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_carry <= 1'b0;
      r_sat   <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_sane;
      r_carry <= 1'b0;
      r_sat   <= 1'b0;
    end else if (bus.en) begin
      if (!w_tc) begin
        r_count <= w_next;
        r_carry <= 1'b0;
        r_sat   <= 1'b0;
      end else if (WRAP_EN != 0) begin
        // The digit-wise step already rolls all-9s to all-0s and vice versa.
        r_count <= w_next;
        r_carry <= 1'b1;
        r_sat   <= 1'b0;
      end else begin
        r_carry <= 1'b0;
        r_sat   <= 1'b1;
      end
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.carry = r_carry;
  assign bus.sat   = r_sat;
  assign bus.tc    = w_tc;

endmodule

`default_nettype wire
